// File: rtl/tsp_pkg.sv
// Constants and types shared by users of three_stage_pipeline and its result collector.
package tsp_pkg;

  localparam int TSP_LATENCY = 2;
  localparam int TSP_DEPTH   = 4;

  typedef logic [$clog2(TSP_DEPTH+1)-1:0] cnt_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, registered state and a zeroed head when empty.
module sync_fifo #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [DWIDTH-1:0]          data_i,
  input  logic                       pop_i,
  output logic [DWIDTH-1:0]          data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic              w_push_ok;
  logic              w_pop_ok;

  assign empty_o   = (r_wr_ptr == r_rd_ptr);
  assign full_o    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = pop_i & ~empty_o;
  // A push into a full FIFO is kept only when the head leaves on the same edge.
  assign w_push_ok = push_i & (~full_o | w_pop_ok);
  assign count_o   = r_wr_ptr - r_rd_ptr;
  assign data_o    = empty_o ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/tsp_result_collector.sv
// Collects results of a non-stallable pipeline into a FIFO, issuing credits so none is lost.
module tsp_result_collector
  import tsp_pkg::*;
#(
  parameter int DWIDTH  = 8,
  parameter int DEPTH   = 4,
  parameter int LATENCY = TSP_LATENCY
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic [DWIDTH-1:0]          res_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DWIDTH-1:0]          out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o
);

  localparam int SW = $clog2(DEPTH + LATENCY + 1);

  logic [LATENCY-1:0] r_vpipe;
  logic               r_overflow;
  logic               w_accept;
  logic               w_capture;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [SW-1:0]      w_inflight;
  logic [SW-1:0]      w_credit;

  assign w_accept  = issue_valid_i & issue_ready_o;
  assign w_capture = r_vpipe[LATENCY-1];
  assign w_pop     = out_valid_o & out_ready_i;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LATENCY; i++) w_inflight = w_inflight + SW'(r_vpipe[i]);
  end

  // Every in-flight result already owns a FIFO slot, so credits depend on registered state only.
  assign w_credit      = SW'(count_o) + w_inflight;
  assign issue_ready_o = (w_credit < SW'(DEPTH));
  assign out_valid_o   = ~w_empty;
  assign overflow_o    = r_overflow;

  generate
    if (LATENCY == 1) begin : g_vpipe_1
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_vpipe <= '0;
        else      r_vpipe <= w_accept;
      end
    end else begin : g_vpipe_n
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_vpipe <= '0;
        else      r_vpipe <= {r_vpipe[LATENCY-2:0], w_accept};
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_overflow <= 1'b0;
    else if (w_capture && w_full && !w_pop)  r_overflow <= 1'b1;
  end

  sync_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (w_capture),
    .data_i  (res_i),
    .pop_i   (w_pop),
    .data_o  (out_data_o),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (count_o)
  );

endmodule
